keyscan_enc: RTL and testbench

//  Parametrised successor to the 16-key priority encoder for the keypad front end.

---
 rtl/keyscan_enc.sv | 210 +++++++++++++++++++++
 tb/tb_keyscan_enc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keyscan_enc.sv
// keyscan_enc: synchronises and debounces NKEYS raw key lines, priority-encodes
// the stable set and issues one valid/ready event per press, with optional
// auto-repeat while the key stays held.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no key tracked; the next debounced press is emitted at once
// HOLD   | tracking key r_cur, counting towards the first auto-repeat
// REPEAT | auto-repeating r_cur every REPEAT_PERIOD cycles
module keyscan_enc #(
    parameter int NKEYS         = 16,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    localparam int KW           = $clog2(NKEYS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [NKEYS-1:0] keys,
    input  logic          repeat_en,
    input  logic          ev_ready,
    input  logic          ovr_clr,
    output logic          key_in,
    output logic [KW-1:0] key_val,
    output logic          ev_valid,
    output logic [KW-1:0] ev_val,
    output logic          overrun
);

    // Counter widths; both are kept at least one bit wide for degenerate settings.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST  = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [NKEYS-1:0] r_keys_s1;
    logic [NKEYS-1:0] r_keys_s2;
    logic [NKEYS-1:0] r_db;
    logic [CW-1:0]    r_cnt [NKEYS];

    state_t           r_state;
    logic [TW-1:0]    r_tmr;
    logic [KW-1:0]    r_cur;
    logic             r_ev_valid;
    logic [KW-1:0]    r_ev_val;
    logic             r_overrun;

    state_t           w_state_nxt;
    logic [TW-1:0]    w_tmr_nxt;
    logic [KW-1:0]    w_cur_nxt;
    logic             w_emit;
    logic [KW-1:0]    w_emit_val;
    logic             w_release;
    logic             w_key_in;
    logic [KW-1:0]    w_key_val;
    logic             w_accept;
    logic             w_drop;

    // Two-flop synchroniser on every raw key line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_keys_s1 <= '0;
            r_keys_s2 <= '0;
        end else begin
            r_keys_s1 <= keys;
            r_keys_s2 <= r_keys_s1;
        end
    end

    // Per-key debounce: a level change is accepted only after DB_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_db <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (r_keys_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority encoder: scanning downwards leaves the lowest set index.
    always_comb begin
        w_key_in  = |r_db;
        w_key_val = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (r_db[i]) begin
                w_key_val = KW'(i);
            end
        end
    end

    // Event FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    // Event FSM next state; a release outranks any emit in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_cur_nxt   = r_cur;
        w_emit      = 1'b0;
        w_emit_val  = r_cur;
        w_release   = !w_key_in || (w_key_val != r_cur);

        case (r_state)
            IDLE: begin
                if (w_key_in) begin
                    w_emit      = 1'b1;
                    w_emit_val  = w_key_val;
                    w_cur_nxt   = w_key_val;
                    w_tmr_nxt   = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (repeat_en && (r_tmr == RD_LAST)) begin
                    w_emit      = 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = REPEAT;
                end else if (r_tmr != RD_LAST) begin
                    w_tmr_nxt   = r_tmr + 1'b1;
                end
            end
            REPEAT: begin
                if (w_release) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (!repeat_en) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = HOLD;
                end else if (r_tmr == RP_LAST) begin
                    w_emit      = 1'b1;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt   = r_tmr + 1'b1;
                end
            end
            default: begin
                w_tmr_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // An emit lands only if the output slot is empty or being drained now.
    always_comb begin
        w_accept = w_emit && (!r_ev_valid || ev_ready);
        w_drop   = w_emit && r_ev_valid && !ev_ready;
    end

    // Output event register and sticky overrun; a drop beats ovr_clr.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ev_valid <= 1'b0;
            r_ev_val   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ev_valid <= 1'b1;
                r_ev_val   <= w_emit_val;
            end else if (ev_ready) begin
                r_ev_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign key_in   = w_key_in;
    assign key_val  = w_key_val;
    assign ev_valid = r_ev_valid;
    assign ev_val   = r_ev_val;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_keyscan_enc.sv
// Directed bench for keyscan_enc with NKEYS=16, DB_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4. Expected values are hand-derived from the behaviour.
module tb_keyscan_enc;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] keys;
    logic        repeat_en;
    logic        ev_ready;
    logic        ovr_clr;
    logic        key_in;
    logic [3:0]  key_val;
    logic        ev_valid;
    logic [3:0]  ev_val;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    keyscan_enc #(
        .NKEYS(16), .DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clock(clock), .reset(reset), .keys(keys), .repeat_en(repeat_en),
        .ev_ready(ev_ready), .ovr_clr(ovr_clr), .key_in(key_in),
        .key_val(key_val), .ev_valid(ev_valid), .ev_val(ev_val),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Wait (bounded) until ev_valid is seen after an edge.
    task automatic wait_ev(input string tag, input int budget);
        int c;
        c = 0;
        while (!ev_valid && c < budget) begin
            tick();
            c++;
        end
        check(tag, ev_valid, 1'b1);
    endtask

    logic [31:0] evmask;
    logic        seen_key;
    logic        seen_ev;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; keys = '0; repeat_en = 1'b0; ev_ready = 1'b1; ovr_clr = 1'b0;
        tick(3);
        check("rst_key_in", key_in, 0);
        check("rst_key_val", key_val, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_val", ev_val, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick(2);

        // 1: single press of key 5, no repeat
        keys = 16'h0020;
        tick(6);
        check("t1_key_val", key_val, 5);
        check("t1_key_in", key_in, 1);
        check("t1_early", ev_valid, 0);
        tick();
        check("t1_ev_valid", ev_valid, 1);
        check("t1_ev_val", ev_val, 5);
        tick();
        check("t1_one_cycle", ev_valid, 0);
        seen_ev = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen_ev |= ev_valid;
        end
        check("t1_no_more", seen_ev, 0);
        keys = '0;
        tick(8);
        check("t1_released", key_in, 0);

        // 2: 3-clock glitch on key 3 must be rejected
        keys = 16'h0008;
        tick(3);
        keys = '0;
        seen_key = 1'b0;
        seen_ev  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen_key |= key_in;
            seen_ev  |= ev_valid;
        end
        check("t2_key_in", seen_key, 0);
        check("t2_ev", seen_ev, 0);

        // 3: keys 0 and 15, then drop key 0
        keys = 16'h8001;
        tick(7);
        check("t3_ev_valid", ev_valid, 1);
        check("t3_ev_val0", ev_val, 0);
        check("t3_key_val0", key_val, 0);
        keys = 16'h8000;
        tick(5);
        check("t3_key_val_hold", key_val, 0);
        tick();
        check("t3_key_val15", key_val, 15);
        check("t3_no_ev_yet", ev_valid, 0);
        tick();
        check("t3_idle_cycle", ev_valid, 0);
        tick();
        check("t3_ev_valid15", ev_valid, 1);
        check("t3_ev_val15", ev_val, 15);
        keys = '0;
        tick(10);

        // 4: auto-repeat on key 9
        repeat_en = 1'b1;
        keys = 16'h0200;
        wait_ev("t4_first", 20);
        check("t4_first_val", ev_val, 9);
        evmask = '0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ev_valid) begin
                evmask[k] = 1'b1;
                check($sformatf("t4_val_at_%0d", k), ev_val, 9);
            end
            if (k == 24) keys = '0;
        end
        check("t4_times", evmask, 32'h1111_1100);
        tick(5);
        check("t4_idle_ev", ev_valid, 0);
        check("t4_idle_key", key_in, 0);
        repeat_en = 1'b0;

        // 5: overrun while the consumer stalls
        ev_ready = 1'b0;
        keys = 16'h0004;
        tick(7);
        check("t5_ev_valid", ev_valid, 1);
        check("t5_ev_val2", ev_val, 2);
        keys = '0;
        tick(10);
        check("t5_no_ovr", overrun, 0);
        keys = 16'h0010;
        tick(6);
        check("t5_ovr_pre", overrun, 0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t5_ovr_set_wins", overrun, 1);
        check("t5_ev_val_kept", ev_val, 2);
        check("t5_ev_valid_kept", ev_valid, 1);
        ev_ready = 1'b1;
        tick();
        check("t5_ev_drain", ev_valid, 0);
        check("t5_ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t5_ovr_clr", overrun, 0);
        keys = '0;
        tick(10);

        // 6: reset while repeating, key still held
        repeat_en = 1'b1;
        keys = 16'h0200;
        wait_ev("t6_first", 20);
        tick(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_key_in", key_in, 0);
        check("t6_key_val", key_val, 0);
        check("t6_ev_valid", ev_valid, 0);
        check("t6_ev_val", ev_val, 0);
        check("t6_overrun", overrun, 0);
        tick(6);
        check("t6_early", ev_valid, 0);
        tick();
        check("t6_ev_valid_new", ev_valid, 1);
        check("t6_ev_val_new", ev_val, 9);
        keys = '0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
